div: RTL and testbench

Sequential unsigned integer divider, the inverse of the CPU's 24-bit combinational multiplier. Computes quotient and remainder of a 24-bit dividend by a 24-bit divisor, one quotient bit per clock (restoring shift-subtract), under a start/busy/done handshake. Sits beside the multiplier in the ALU execute path and stalls the single-cycle core while `busy` is high.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 30 +++
 rtl/div.sv | 118 +++++++++++
 tb/tb_div.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared width, counter and FSM state definitions
// for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 24;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
// Ports: r_i/q_i/divisor_i in, r_o/q_o next partial state.
module div_step #(
  parameter int W = 24
) (
  input  logic [W:0]   r_i,
  input  logic [W-1:0] q_i,
  input  logic [W-1:0] divisor_i,
  output logic [W:0]   r_o,
  output logic [W-1:0] q_o
);

  logic [W:0]   r_sh;
  logic [W-1:0] q_sh;
  logic [W:0]   d_ext;

  assign r_sh  = {r_i[W-1:0], q_i[W-1]};
  assign q_sh  = {q_i[W-2:0], 1'b0};
  assign d_ext = {1'b0, divisor_i};

  always_comb begin
    r_o = r_sh;
    q_o = q_sh;
    if (r_sh >= d_ext) begin
      r_o = r_sh - d_ext;
      q_o = {q_sh[W-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/div.sv
// div: 24-bit unsigned sequential divider, one quotient bit
// per clock, start/busy/done handshake, divide-by-zero flag.
// Ports: clk, rst_n, start, dividend, divisor in;
//        busy, done, quotient, remainder, div_by_zero out.
module div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   step_r;
  logic [WIDTH-1:0] step_q;

  div_step #(
    .W(WIDTH)
  ) u_step (
    .r_i      (r_q),
    .q_i      (q_q),
    .divisor_i(dvs_q),
    .r_o      (step_r),
    .q_o      (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (divisor != '0) begin
            state_d = CALC;
            q_d     = dividend;
            r_d     = '0;
            cnt_d   = CW'(WIDTH);
            dvs_d   = divisor;
            dbz_d   = 1'b0;
          end else begin
            // Zero divisor finishes at once, no iteration.
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          quo_d   = step_q;
          rem_d   = step_r[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div.sv
// tb_div: directed self-checking bench for the divider.
// Drives and samples on the falling clock edge.
module tb_div;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [23:0] dividend;
  logic [23:0] divisor;
  logic        busy;
  logic        done;
  logic [23:0] quotient;
  logic [23:0] remainder;
  logic        div_by_zero;

  int ncmp = 0;
  int nerr = 0;
  int lat;
  int bcnt;
  int lat2;
  int seen;
  bit stable;

  div dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, drop start after the accepting
  // edge and scramble operands; count cycles to done.
  task automatic run(input logic [23:0] a,
                     input logic [23:0] b);
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    lat = 0;
    bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      dividend = 24'h5A5A5A;
      divisor = 24'h000003;
      lat++;
      if (busy) bcnt++;
      if (done) break;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quo", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(24'd100, 24'd7);
    chk("t1_lat", lat, 25);
    chk("t1_busy", bcnt, 24);
    chk("t1_quo", quotient, 14);
    chk("t1_rem", remainder, 2);
    chk("t1_dbz", div_by_zero, 0);
    @(negedge clk);
    chk("t1_done_1cyc", done, 0);
    chk("t1_hold_quo", quotient, 14);

    run(24'hFFFFFF, 24'd1);
    chk("max_by1_quo", quotient, 32'hFFFFFF);
    chk("max_by1_rem", remainder, 0);
    run(24'hFFFFFF, 24'hFFFFFF);
    chk("max_max_quo", quotient, 1);
    chk("max_max_rem", remainder, 0);
    chk("max_max_lat", lat, 25);
    run(24'd3, 24'd10);
    chk("small_quo", quotient, 0);
    chk("small_rem", remainder, 3);
    run(24'd0, 24'd5);
    chk("zero_quo", quotient, 0);
    chk("zero_rem", remainder, 0);

    run(24'd5, 24'd0);
    chk("dz_lat", lat, 1);
    chk("dz_busy", bcnt, 0);
    chk("dz_quo", quotient, 32'hFFFFFF);
    chk("dz_rem", remainder, 5);
    chk("dz_flag", div_by_zero, 1);
    run(24'd9, 24'd3);
    chk("after_dz_quo", quotient, 3);
    chk("after_dz_rem", remainder, 0);
    chk("after_dz_flag", div_by_zero, 0);

    // Second start while busy must be ignored.
    @(negedge clk);
    start = 1'b1;
    dividend = 24'd1000;
    divisor = 24'd3;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 10) begin
        start = 1'b1;
        dividend = 24'd50;
        divisor = 24'd5;
      end else begin
        start = 1'b0;
      end
      if (done) break;
    end
    chk("ign_lat", lat, 25);
    chk("ign_quo", quotient, 333);
    chk("ign_rem", remainder, 1);

    // Reset in the middle of a calculation.
    @(negedge clk);
    start = 1'b1;
    dividend = 24'd1000;
    divisor = 24'd3;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("mid_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_quo", quotient, 0);
    chk("ar_rem", remainder, 0);
    chk("ar_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("ar_no_done", seen, 0);
    run(24'd20, 24'd6);
    chk("post_rst_quo", quotient, 3);
    chk("post_rst_rem", remainder, 2);

    // Back-to-back with start held high through DONE.
    @(negedge clk);
    start = 1'b1;
    dividend = 24'd77;
    divisor = 24'd7;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    chk("b2b1_lat", lat, 25);
    chk("b2b1_quo", quotient, 11);
    chk("b2b1_rem", remainder, 0);
    dividend = 24'd78;
    lat2 = 0;
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      lat2++;
      if (done) break;
      if (quotient !== 24'd11 || remainder !== 24'd0) stable = 1'b0;
    end
    chk("b2b_gap", lat2, 25);
    chk("b2b_stable", stable, 1);
    chk("b2b2_quo", quotient, 11);
    chk("b2b2_rem", remainder, 1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
